// File: rtl/bus_timer_if.sv
// Register-bus bundle between the bridge and the bus timer.
interface bus_timer_if;
    logic        Sel;
    logic [31:0] Addr;
    logic [3:0]  ByteEn;
    logic [31:0] WData;
    logic [31:0] RData;

    modport master (output Sel, Addr, ByteEn, WData, input RData);
    modport slave  (input Sel, Addr, ByteEn, WData, output RData);
endinterface

// File: rtl/bus_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes,
// byte-lane register writes and a maskable level interrupt.
module bus_timer (
    input  logic       Clk,
    input  logic       Rst,
    bus_timer_if.slave bus,
    output logic       IRQ
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    state_e      state_q;
    logic        en_q;
    logic [1:0]  mode_q;
    logic        im_q;
    logic        irq_flag_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic [31:0] preset_d;

    logic wr_en;
    logic ctrl_wr;
    logic preset_wr;
    logic unused_addr;

    assign wr_en       = bus.Sel && (bus.ByteEn != 4'b0000);
    assign ctrl_wr     = wr_en && (bus.Addr[3:2] == 2'd0);
    assign preset_wr   = wr_en && (bus.Addr[3:2] == 2'd1);
    assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

    always_comb begin
        preset_d = preset_q;
        for (int i = 0; i < 4; i++) begin
            if (bus.ByteEn[i]) begin
                preset_d[8*i +: 8] = bus.WData[8*i +: 8];
            end
        end
    end

    always_comb begin
        bus.RData = 32'd0;
        if (bus.Sel) begin
            case (bus.Addr[3:2])
                2'd0:    bus.RData = {28'd0, im_q, mode_q, en_q};
                2'd1:    bus.RData = preset_q;
                2'd2:    bus.RData = count_q;
                default: bus.RData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            irq_flag_q <= 1'b0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en_q) state_q <= StLoad;
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!en_q) begin
                        state_q <= StIdle;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        // Count of 0 or 1 both finish here, so PRESET=0 acts as 1.
                        count_q    <= 32'd0;
                        irq_flag_q <= 1'b1;
                        state_q    <= StInt;
                    end
                end
                StInt: begin
                    if (mode_q == 2'b01) begin
                        irq_flag_q <= 1'b0;
                        state_q    <= StLoad;
                    end else begin
                        en_q    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Bus writes come last so they override the FSM's own updates.
            if (ctrl_wr) begin
                irq_flag_q <= 1'b0;
                if (bus.ByteEn[0]) begin
                    en_q   <= bus.WData[0];
                    mode_q <= bus.WData[2:1];
                    im_q   <= bus.WData[3];
                end
            end
            if (preset_wr) preset_q <= preset_d;
        end
    end

    assign IRQ = im_q & irq_flag_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer; each task covers one feature.
module tb_bus_timer;

    localparam logic [31:0] ACtrl   = 32'h0;
    localparam logic [31:0] APreset = 32'h4;
    localparam logic [31:0] ACount  = 32'h8;
    localparam logic [31:0] ARsvd   = 32'hC;

    logic clk;
    logic rst;
    logic irq;
    int   total;
    int   bad;

    bus_timer_if bus_if ();

    bus_timer dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus_if),
        .IRQ (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write lands on the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus_if.Sel    = 1'b1;
        bus_if.Addr   = a;
        bus_if.ByteEn = be;
        bus_if.WData  = d;
        @(posedge clk);
        #1;
        bus_if.Sel    = 1'b0;
        bus_if.ByteEn = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.Sel    = 1'b1;
        bus_if.Addr   = a;
        bus_if.ByteEn = 4'b0000;
        #1;
        d = bus_if.RData;
        bus_if.Sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        tick();
        wr(ACtrl, 4'hF, 32'hF);
        wr(APreset, 4'hF, 32'h5);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 4), v);
            total++;
            if (v !== 32'd0) begin
                bad++;
                $display("FAIL reset_rdata addr=%0d got=%h exp=0", i * 4, v);
            end
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        logic [31:0] exp_cnt;
        wr(APreset, 4'hF, 32'd5);
        wr(ACtrl, 4'hF, 32'h9);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_irq_e0 got=%b exp=0", irq);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            rd(ACount, v);
            exp_cnt = (k >= 2 && k <= 6) ? 32'(7 - k) : 32'd0;
            total++;
            if (irq !== (k >= 7)) begin
                bad++;
                $display("FAIL oneshot_irq e%0d got=%b exp=%b", k, irq, (k >= 7));
            end
            total++;
            if (v !== exp_cnt) begin
                bad++;
                $display("FAIL oneshot_count e%0d got=%0d exp=%0d", k, v, exp_cnt);
            end
        end
        rd(ACtrl, v);
        total++;
        if (v !== 32'h8) begin
            bad++;
            $display("FAIL oneshot_ctrl got=%h exp=8", v);
        end
        tick();
        tick();
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_irq_held got=%b exp=1", irq);
        end
        wr(ACtrl, 4'hF, 32'h8);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_irq_clear got=%b exp=0", irq);
        end
        wr(ACtrl, 4'hF, 32'h0);
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        logic [31:0] exp_cnt;
        wr(APreset, 4'hF, 32'd2);
        wr(ACtrl, 4'hF, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            tick();
            rd(ACount, v);
            if (k < 2) exp_cnt = 32'd0;
            else begin
                case ((k - 2) % 4)
                    0:       exp_cnt = 32'd2;
                    1:       exp_cnt = 32'd1;
                    default: exp_cnt = 32'd0;
                endcase
            end
            total++;
            if (irq !== ((k % 4) == 0)) begin
                bad++;
                $display("FAIL reload_irq e%0d got=%b exp=%b", k, irq, ((k % 4) == 0));
            end
            total++;
            if (v !== exp_cnt) begin
                bad++;
                $display("FAIL reload_count e%0d got=%0d exp=%0d", k, v, exp_cnt);
            end
        end
        wr(ACtrl, 4'hF, 32'h0);
        tick();
        tick();
        tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reload_stop_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_mask();
        logic [31:0] v;
        wr(APreset, 4'hF, 32'd1);
        wr(ACtrl, 4'hF, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (irq !== 1'b0) begin
                bad++;
                $display("FAIL mask_irq e%0d got=%b exp=0", k, irq);
            end
        end
        rd(ACtrl, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL mask_ctrl got=%h exp=0", v);
        end
        wr(APreset, 4'hF, 32'd7);
        tick();
        tick();
        tick();
        rd(ACount, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL mask_idle_count got=%0d exp=0", v);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] v;
        wr(APreset, 4'hF, 32'h0);
        wr(APreset, 4'b0101, 32'hAABBCCDD);
        rd(APreset, v);
        total++;
        if (v !== 32'h00BB00DD) begin
            bad++;
            $display("FAIL lanes_0101 got=%h exp=00bb00dd", v);
        end
        wr(APreset, 4'b1100, 32'h11223344);
        rd(APreset, v);
        total++;
        if (v !== 32'h112200DD) begin
            bad++;
            $display("FAIL lanes_1100 got=%h exp=112200dd", v);
        end
        wr(ACount, 4'hF, 32'hFFFFFFFF);
        rd(ACount, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL count_ro got=%h exp=0", v);
        end
        wr(ARsvd, 4'hF, 32'h12345678);
        rd(ARsvd, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL rsvd_read got=%h exp=0", v);
        end
        rd(APreset, v);
        total++;
        if (v !== 32'h112200DD) begin
            bad++;
            $display("FAIL rsvd_side_effect got=%h exp=112200dd", v);
        end
        wr(ACtrl, 4'hF, 32'hFFFFFFF6);
        rd(ACtrl, v);
        total++;
        if (v !== 32'h6) begin
            bad++;
            $display("FAIL ctrl_bits got=%h exp=6", v);
        end
        wr(ACtrl, 4'hF, 32'h0);
        bus_if.Sel  = 1'b0;
        bus_if.Addr = APreset;
        #1;
        total++;
        if (bus_if.RData !== 32'd0) begin
            bad++;
            $display("FAIL sel0_rdata got=%h exp=0", bus_if.RData);
        end
    endtask

    task automatic test_preset_zero();
        wr(APreset, 4'hF, 32'd0);
        wr(ACtrl, 4'hF, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (irq !== (k >= 3)) begin
                bad++;
                $display("FAIL preset0_irq e%0d got=%b exp=%b", k, irq, (k >= 3));
            end
        end
        wr(ACtrl, 4'hF, 32'h0);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL preset0_clear got=%b exp=0", irq);
        end
    endtask

    task automatic test_abort_and_reset();
        logic [31:0] v;
        wr(APreset, 4'hF, 32'd10);
        wr(ACtrl, 4'hF, 32'h1);
        for (int k = 1; k <= 5; k++) tick();
        rd(ACount, v);
        total++;
        if (v !== 32'd7) begin
            bad++;
            $display("FAIL abort_pre got=%0d exp=7", v);
        end
        wr(ACtrl, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        rd(ACount, v);
        total++;
        if (v !== 32'd6) begin
            bad++;
            $display("FAIL abort_hold got=%0d exp=6", v);
        end
        // Restart; a PRESET write mid-count must not disturb COUNT.
        wr(ACtrl, 4'hF, 32'h1);
        tick();
        tick();
        wr(APreset, 4'hF, 32'd3);
        rd(ACount, v);
        total++;
        if (v !== 32'd9) begin
            bad++;
            $display("FAIL preset_midcount got=%0d exp=9", v);
        end
        tick();
        rd(ACount, v);
        total++;
        if (v !== 32'd8) begin
            bad++;
            $display("FAIL restart_count got=%0d exp=8", v);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 4), v);
            total++;
            if (v !== 32'd0) begin
                bad++;
                $display("FAIL midrst_rdata addr=%0d got=%h exp=0", i * 4, v);
            end
        end
        tick();
        tick();
        tick();
        rd(ACount, v);
        total++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle count=%0d irq=%b exp count=0 irq=0", v, irq);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus_if.Sel    = 1'b0;
        bus_if.Addr   = 32'd0;
        bus_if.ByteEn = 4'b0000;
        bus_if.WData  = 32'd0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mask();
        test_byte_lanes();
        test_preset_zero();
        test_abort_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
